// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async FIFO constants and Gray/binary helpers
package fifo_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 3;

    // Zero-extended operands leave the upper bits of either conversion at zero,
    // so one 32-bit version serves every pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_ctrl_if.sv
// rtl/wptr_full_ctrl_if.sv - write-side request/status bundle for the FIFO write controller
interface wptr_full_ctrl_if import fifo_pkg::*; #(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    logic                  winc;
    logic                  ovf_clr;
    logic [ADDR_WIDTH:0]   rptr_sync;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH:0]   wptr;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wlevel;
    logic                  overflow;

    modport master (
        output winc, ovf_clr, rptr_sync,
        input  wen, waddr, wptr, full, almost_full, wlevel, overflow
    );

    modport slave (
        input  winc, ovf_clr, rptr_sync,
        output wen, waddr, wptr, full, almost_full, wlevel, overflow
    );
endinterface

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - combinational Gray-to-binary converter (XOR prefix from the MSB)
module gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);
    always_comb begin
        bin = '0;
        for (int i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end
endmodule

// File: rtl/wptr_full_ctrl.sv
// rtl/wptr_full_ctrl.sv - write pointer, full/almost_full, fill level and sticky overflow
module wptr_full_ctrl import fifo_pkg::*; #(
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int AFULL_THRESH = 6
) (
    input logic             wclk,
    input logic             rst_n,
    wptr_full_ctrl_if.slave bus
);
    localparam int AW = ADDR_WIDTH;
    localparam int PW = ADDR_WIDTH + 1;

    logic [AW:0]   wbin;
    logic [AW:0]   wbin_next;
    logic [AW:0]   wgray_next;
    logic [AW:0]   rbin_sync;
    logic [AW:0]   level_next;
    logic          full_next;
    logic          afull_next;
    logic          accept;

    logic [AW:0]   wptr_q;
    logic [AW-1:0] waddr_q;
    logic [AW:0]   wlevel_q;
    logic          full_q;
    logic          afull_q;
    logic          ovf_q;

    gray2bin #(.W(PW)) u_rgray2bin (
        .gray (bus.rptr_sync),
        .bin  (rbin_sync)
    );

    assign accept     = bus.winc & ~full_q;
    assign wbin_next  = wbin + {{AW{1'b0}}, accept};
    assign wgray_next = PW'(bin2gray(32'(wbin_next)));
    assign level_next = wbin_next - rbin_sync;

    // Full when the write Gray pointer is one lap ahead: top two bits inverted.
    assign full_next  = (wgray_next == {~bus.rptr_sync[AW:AW-1], bus.rptr_sync[AW-2:0]});
    assign afull_next = (32'(level_next) >= AFULL_THRESH);

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            wbin     <= '0;
            wptr_q   <= '0;
            waddr_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            wlevel_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wbin     <= wbin_next;
            wptr_q   <= wgray_next;
            waddr_q  <= wbin_next[AW-1:0];
            full_q   <= full_next;
            afull_q  <= afull_next;
            wlevel_q <= level_next;
            // A fresh overflow wins over a simultaneous clear.
            if (bus.winc && full_q) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.wen         = accept;
    assign bus.waddr       = waddr_q;
    assign bus.wptr        = wptr_q;
    assign bus.full        = full_q;
    assign bus.almost_full = afull_q;
    assign bus.wlevel      = wlevel_q;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb/tb_wptr_full_ctrl.sv - self-checking bench for wptr_full_ctrl against an occupancy model
module tb_wptr_full_ctrl;
    import fifo_pkg::*;

    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int THR   = 6;

    logic wclk  = 1'b0;
    logic rst_n = 1'b0;

    wptr_full_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    wptr_full_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(THR)) dut (
        .wclk  (wclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 wclk = ~wclk;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    bit m_full = 1'b0;
    bit m_ovf  = 1'b0;

    // Reference pointer code: the n-th position of a 4-bit reflected Gray sequence.
    function automatic logic [3:0] gray_of(input int n);
        int b;
        b = n % 16;
        return 4'(b ^ (b >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int lvl;
        lvl = wr_cnt - rd_cnt;
        chk({tag, ".waddr"},    32'(bus.waddr),       32'(wr_cnt % DEPTH));
        chk({tag, ".wptr"},     32'(bus.wptr),        32'(gray_of(wr_cnt)));
        chk({tag, ".full"},     32'(bus.full),        32'(m_full));
        chk({tag, ".afull"},    32'(bus.almost_full), 32'(lvl >= THR));
        chk({tag, ".wlevel"},   32'(bus.wlevel),      32'(lvl));
        chk({tag, ".overflow"}, 32'(bus.overflow),    32'(m_ovf));
    endtask

    task automatic step(input string tag, input bit w, input bit clr);
        @(negedge wclk);
        bus.winc      = w;
        bus.ovf_clr   = clr;
        bus.rptr_sync = gray_of(rd_cnt);
        #1 chk({tag, ".wen"}, 32'(bus.wen), 32'(w && !m_full));
        @(posedge wclk);
        if (w && m_full)  m_ovf = 1'b1;
        else if (clr)     m_ovf = 1'b0;
        if (w && !m_full) wr_cnt++;
        m_full = ((wr_cnt - rd_cnt) == DEPTH);
        #1 check_all(tag);
    endtask

    task automatic model_reset();
        wr_cnt = 0;
        rd_cnt = 0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge wclk);
        rst_n         = 1'b0;
        bus.winc      = 1'b0;
        bus.ovf_clr   = 1'b0;
        bus.rptr_sync = '0;
        model_reset();
        @(negedge wclk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.winc      = 1'b0;
        bus.ovf_clr   = 1'b0;
        bus.rptr_sync = '0;
        @(posedge wclk);
        #1 check_all("rst");
        @(negedge wclk);
        rst_n = 1'b1;

        // Asynchronous reset pulse in the middle of a cycle
        for (int i = 0; i < 3; i++) step("pre", 1'b1, 1'b0);
        @(posedge wclk);
        #3;
        bus.winc = 1'b0;
        rst_n    = 1'b0;
        bus.rptr_sync = '0;
        model_reset();
        #1 check_all("async_rst");
        chk("async_rst.wen", 32'(bus.wen), 32'd0);
        @(negedge wclk);
        rst_n = 1'b1;
        step("post_rst", 1'b0, 1'b0);

        // Fill to full with the reader parked at zero
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0);
        chk("fill.wptr_c",   32'(bus.wptr),   32'hc);
        chk("fill.wlevel_c", 32'(bus.wlevel), 32'd8);

        // Overflow and its clear, including clear racing a new overflow
        step("ovf", 1'b1, 1'b0);
        chk("ovf.flag", 32'(bus.overflow), 32'd1);
        chk("ovf.wptr", 32'(bus.wptr),     32'hc);
        step("ovf_clr", 1'b0, 1'b1);
        chk("ovf_clr.flag", 32'(bus.overflow), 32'd0);
        step("ovf_race", 1'b1, 1'b1);
        chk("ovf_race.flag", 32'(bus.overflow), 32'd1);
        step("ovf_clr2", 1'b0, 1'b1);

        // Drain one entry, then refill
        rd_cnt = 1;
        step("drain", 1'b0, 1'b0);
        chk("drain.full",   32'(bus.full),   32'd0);
        chk("drain.wlevel", 32'(bus.wlevel), 32'd7);
        step("refill", 1'b1, 1'b0);
        chk("refill.full", 32'(bus.full), 32'd1);
        chk("refill.wptr", 32'(bus.wptr), 32'hd);

        // Wrap with the reader trailing one cycle behind
        do_reset();
        for (int i = 0; i < 20; i++) begin
            rd_cnt = wr_cnt;
            step("wrap", 1'b1, 1'b0);
            chk("wrap.nofull", 32'(bus.full), 32'd0);
        end

        // Read pointer jumping several Gray steps at once
        do_reset();
        for (int i = 0; i < 6; i++) step("jump_fill", 1'b1, 1'b0);
        chk("jump.afull_pre", 32'(bus.almost_full), 32'd1);
        rd_cnt = 4;
        step("jump", 1'b0, 1'b0);
        chk("jump.wlevel", 32'(bus.wlevel),      32'd2);
        chk("jump.afull",  32'(bus.almost_full), 32'd0);

        // Randomised traffic with arbitrary reader advances
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1)
                rd_cnt += $urandom_range(0, wr_cnt - rd_cnt);
            step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
